// File: rtl/edn_lfsr_responder_pkg.sv
// Shared constants, FSM state type and LFSR step function for edn_lfsr_responder.
package edn_lfsr_responder_pkg;

    // Galois feedback taps for the 32-bit right-shifting LFSR.
    localparam logic [31:0] EdnLfsrPoly = 32'h80200003;

    // Width of the WAIT down-counter: covers 15 + 3 cycles of optional jitter.
    localparam int unsigned LatW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } edn_rsp_state_e;

    // One Galois step: shift right, fold the polynomial in when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? EdnLfsrPoly : 32'h0);
    endfunction

endpackage : edn_lfsr_responder_pkg

// File: rtl/edn_pkg.sv
// Minimal EDN request/response types for an entropy consumer and its endpoint.
package edn_pkg;

    typedef struct packed {
        logic edn_req;
    } edn_req_t;

    typedef struct packed {
        logic        edn_ack;
        logic        edn_fips;
        logic [31:0] edn_bus;
    } edn_rsp_t;

endpackage : edn_pkg

// File: rtl/edn_lfsr32.sv
// 32-bit Galois LFSR with seed load, single-step advance and zero-seed substitution.
// A zero seed would lock the LFSR at zero forever, so DefaultSeed is loaded instead.
module edn_lfsr32
    import edn_lfsr_responder_pkg::*;
#(
    parameter logic [31:0] DefaultSeed = 32'h4807379f
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        advance_i,
    output logic [31:0] lfsr_o
);

    logic [31:0] lfsr_q, lfsr_d;

    // Load has priority over advance; the top never requests both at once.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = (seed_i == 32'h0) ? DefaultSeed : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // LFSR state register, returns to DefaultSeed on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= DefaultSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule : edn_lfsr32

// File: rtl/edn_lfsr_responder.sv
// EDN endpoint model: answers req/ack requests with pseudo-random 32-bit words.
// Handshake: the consumer raises edn_req and holds it until it sees edn_ack for
// exactly one cycle; edn_bus/edn_fips are valid only in that ack cycle. Dropping
// edn_req before ack abandons the request and sets the sticky proto_err_o.
// Optional macro EDN_LFSR_RESPONDER_RAND_LAT_EN adds 0..3 cycles of jitter
// (taken from lfsr[1:0]) to the WAIT count loaded on accept.
module edn_lfsr_responder
    import edn_lfsr_responder_pkg::*;
#(
    parameter int unsigned LatencyCycles = 2,
    parameter logic [31:0] DefaultSeed   = 32'h4807379f,
    parameter int unsigned CntW          = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  edn_pkg::edn_req_t  edn_i,
    output edn_pkg::edn_rsp_t  edn_o,
    input  logic               enable_i,
    input  logic               fips_i,
    input  logic [31:0]        seed_i,
    input  logic               seed_load_i,
    output logic [CntW-1:0]    words_served_o,
    output logic               proto_err_o
);

    edn_rsp_state_e    state_q, state_d;
    logic [LatW-1:0]   cnt_q, cnt_d;
    logic [CntW-1:0]   words_q, words_d;
    logic              err_q, err_d;
    edn_pkg::edn_rsp_t rsp_q, rsp_d;

    logic              lfsr_load;
    logic              lfsr_advance;
    logic [31:0]       lfsr;
    logic [LatW-1:0]   accept_lat;

    edn_lfsr32 #(
        .DefaultSeed (DefaultSeed)
    ) u_lfsr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (lfsr_load),
        .seed_i    (seed_i),
        .advance_i (lfsr_advance),
        .lfsr_o    (lfsr)
    );

`ifdef EDN_LFSR_RESPONDER_RAND_LAT_EN
    // Wait count on accept: fixed latency plus 0..3 cycles of LFSR-derived jitter.
    assign accept_lat = LatW'(LatencyCycles) + {{(LatW-2){1'b0}}, lfsr[1:0]};
`else
    // Wait count on accept: fixed latency only.
    assign accept_lat = LatW'(LatencyCycles);
`endif

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle ACK.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Seeding wins over accepting; the request is picked up next cycle.
                if (seed_load_i) begin
                    lfsr_load = 1'b1;
                end else if (enable_i && edn_i.edn_req) begin
                    if (accept_lat == '0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = accept_lat;
                    end
                end
            end
            WAIT: begin
                // An abandoned request leaves the LFSR untouched.
                if (!edn_i.edn_req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACK: begin
                // The served word is consumed on the way out of ACK.
                state_d      = IDLE;
                lfsr_advance = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Response and served-word counter are loaded on the edge entering ACK so the
    // registered outputs line up with the ACK state.
    always_comb begin
        rsp_d   = '0;
        words_d = words_q;
        if (state_d == ACK) begin
            rsp_d.edn_ack  = 1'b1;
            rsp_d.edn_fips = fips_i;
            rsp_d.edn_bus  = lfsr;
            if (words_q != '1) begin
                words_d = words_q + 1'b1;
            end
        end
    end

    // State, counters and response registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            err_q   <= 1'b0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            err_q   <= err_d;
            rsp_q   <= rsp_d;
        end
    end

    assign edn_o          = rsp_q;
    assign words_served_o = words_q;
    assign proto_err_o    = err_q;

endmodule : edn_lfsr_responder

// File: tb/tb_edn_lfsr_responder.sv
// Directed + randomized bench for edn_lfsr_responder with a reference word model.
module tb_edn_lfsr_responder;

  localparam int unsigned CNT_W   = 3;
  localparam logic [31:0] DEF_SEED = 32'h4807379f;
  localparam logic [31:0] POLY     = 32'h80200003;
  localparam int          LAT      = 4;  // edges from req sampled to ack visible
  localparam int          BOUND    = 40;

  logic              clk;
  logic              rst;
  edn_pkg::edn_req_t edn_req;
  edn_pkg::edn_rsp_t edn_rsp;
  logic              enable;
  logic              fips;
  logic [31:0]       seed;
  logic              seed_load;
  logic [CNT_W-1:0]  words_served;
  logic              proto_err;

  int vectors;
  int miscompares;

  // reference model state
  logic [31:0] model_word;
  int          model_served;

  edn_lfsr_responder #(
    .LatencyCycles (2),
    .DefaultSeed   (DEF_SEED),
    .CntW          (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .edn_i          (edn_req),
    .edn_o          (edn_rsp),
    .enable_i       (enable),
    .fips_i         (fips),
    .seed_i         (seed),
    .seed_load_i    (seed_load),
    .words_served_o (words_served),
    .proto_err_o    (proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // next word of the sequence, written as plain division and xor
  function automatic logic [31:0] model_next(input logic [31:0] x);
    logic [31:0] r;
    r = x / 2;
    if (x % 2 == 1) r = r ^ POLY;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] model_count();
    int sat;
    sat = (1 << CNT_W) - 1;
    return (model_served > sat) ? CNT_W'(sat) : CNT_W'(model_served);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one full request; counts edges from the sampling edge until ack is seen
  task automatic txn(input string tag, input logic f, input int exp_lat,
                     input logic sl, input logic [31:0] sd, input logic drop_en);
    int n;
    fips = f;
    edn_req.edn_req = 1'b1;
    seed_load = sl;
    seed = sd;
    if (sl) model_word = (sd == 32'h0) ? DEF_SEED : sd;
    step();
    seed_load = 1'b0;
    if (drop_en) enable = 1'b0;
    n = 1;
    while (!edn_rsp.edn_ack && n < BOUND) begin
      step();
      n++;
    end
    model_served++;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_bus"}, edn_rsp.edn_bus, model_word);
    check({tag, "_fips"}, 32'(edn_rsp.edn_fips), 32'(f));
    check({tag, "_words"}, 32'(words_served), 32'(model_count()));
    edn_req.edn_req = 1'b0;
    step();
    check({tag, "_ack_fall"}, 32'(edn_rsp.edn_ack), 32'h0);
    model_word = model_next(model_word);
    enable = 1'b1;
  endtask

  // watch for any ack over a window of cycles
  task automatic expect_no_ack(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (edn_rsp.edn_ack) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] s;
    vectors = 0;
    miscompares = 0;
    model_word = DEF_SEED;
    model_served = 0;
    rst = 1'b1;
    edn_req.edn_req = 1'b0;
    enable = 1'b0;
    fips = 1'b0;
    seed = 32'h0;
    seed_load = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_rsp", 32'(edn_rsp), 32'h0);
    check("rst_words", 32'(words_served), 32'h0);
    check("rst_err", 32'(proto_err), 32'h0);

    // seed 1, req held high: three known words
    enable = 1'b1;
    seed = 32'h1;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    model_word = 32'h1;
    edn_req.edn_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!edn_rsp.edn_ack && n < BOUND) begin
        step();
        n++;
      end
      model_served++;
      check($sformatf("held_bus%0d", i), edn_rsp.edn_bus, model_word);
      model_word = model_next(model_word);
      if (i == 2) edn_req.edn_req = 1'b0;
      step();
    end
    check("held_words", 32'(words_served), 32'(model_count()));
    check("held_third", model_word, model_next(32'hC0300002));

    // randomized single requests with idle gaps
    for (int i = 0; i < 6; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), LAT, 1'b0, 32'h0, 1'b0);
    end

    // req dropped during WAIT
    edn_req.edn_req = 1'b1;
    step();
    step();
    edn_req.edn_req = 1'b0;
    step();
    check("drop_err", 32'(proto_err), 32'h1);
    expect_no_ack("drop_no_ack", 8);
    txn("after_drop", 1'b1, LAT, 1'b0, 32'h0, 1'b0);
    check("drop_err_sticky", 32'(proto_err), 32'h1);

    // enable low blocks accept
    enable = 1'b0;
    edn_req.edn_req = 1'b1;
    expect_no_ack("disabled_no_ack", 12);
    check("disabled_words", 32'(words_served), 32'(model_count()));
    edn_req.edn_req = 1'b0;
    enable = 1'b1;
    step();
    // enable dropped during WAIT still delivers
    txn("en_drop", 1'b0, LAT, 1'b0, 32'h0, 1'b1);

    // zero seed substitutes DefaultSeed; seed_load beats accept by one cycle
    txn("seed0", 1'b1, LAT + 1, 1'b1, 32'h0, 1'b0);
    check("seed0_word", edn_rsp.edn_bus, 32'h0);
    s = $urandom();
    s[31] = 1'b1;
    txn("seed_rand", 1'b0, LAT + 1, 1'b1, s, 1'b0);

    // seed_load during WAIT is ignored
    edn_req.edn_req = 1'b1;
    fips = 1'b1;
    step();
    seed = $urandom();
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    n = 2;
    while (!edn_rsp.edn_ack && n < BOUND) begin
      step();
      n++;
    end
    model_served++;
    check("wait_seed_lat", 32'(n), 32'(LAT));
    check("wait_seed_bus", edn_rsp.edn_bus, model_word);
    edn_req.edn_req = 1'b0;
    step();
    model_word = model_next(model_word);
    check("sat_words", 32'(words_served), 32'(model_count()));

    // reset during WAIT
    edn_req.edn_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    edn_req.edn_req = 1'b0;
    check("midrst_rsp", 32'(edn_rsp), 32'h0);
    check("midrst_words", 32'(words_served), 32'h0);
    check("midrst_err", 32'(proto_err), 32'h0);
    expect_no_ack("midrst_no_ack", 6);
    model_word = DEF_SEED;
    model_served = 0;
    txn("post_rst", 1'b1, LAT, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_edn_lfsr_responder
